// File: rtl/yolo_deadlock_monitor_nport.sv
// yolo_deadlock_monitor_nport
//   Deadlock monitor for an HLS kernel with N_AXIS stream ports and N_INST
//   sub-instances. Declares deadlock (kernel_block) once the no-progress
//   condition has held for THRESHOLD consecutive cycles. It also keeps a
//   sticky flag, a snapshot of which ports were stalled at detection, and a
//   saturating count of detections.
//
// Ports
//   kernel_monitor_clock  clock, rising edge
//   kernel_monitor_reset  asynchronous reset, active high
//   enable                monitoring active
//   clear                 pulse: clears sticky flag, snapshot and event count
//   axis_block_sigs       per-port outer-side stall
//   inst_idle_sigs        per-instance idle
//   inst_block_sigs       per-instance blocked on an internal channel
//   kernel_block          high while in DEAD
//   deadlock_sticky       set on DEAD entry, held until clear
//   block_snapshot        axis_block_sigs captured on DEAD entry
//   starved_ports         ports the kernel could not reach at detection
//   deadlock_events       saturating count of DEAD entries
//
// state | meaning
// ------+----------------------------------------------------------
// MON   | monitoring, no no-progress run in progress
// PEND  | no-progress run in progress, fewer than THRESHOLD cycles
// DEAD  | deadlock declared, waiting for progress to resume
module yolo_deadlock_monitor_nport #(
  parameter int N_AXIS    = 2,
  parameter int N_INST    = 2,
  parameter int THRESHOLD = 2,
  parameter int EVT_W     = 8
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              kernel_block,
  output logic              deadlock_sticky,
  output logic [N_AXIS-1:0] block_snapshot,
  output logic [N_AXIS-1:0] starved_ports,
  output logic [EVT_W-1:0]  deadlock_events
);

  localparam int CNT_W = $clog2(THRESHOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(THRESHOLD);
  localparam logic [EVT_W-1:0] EVT_MAX  = {EVT_W{1'b1}};

  typedef enum logic [1:0] {
    MON  = 2'd0,
    PEND = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
  logic             raw_block;
  logic             dead_entry;

  // Every instance is idle or blocked, not all are idle, and some port stalls.
  assign raw_block = (&(inst_idle_sigs | inst_block_sigs)) & ~(&inst_idle_sigs)
                     & (|axis_block_sigs);

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state   <= MON;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    dead_entry  = 1'b0;
    if (!enable) begin
      state_nxt   = MON;
      run_cnt_nxt = '0;
    end else begin
      case (state)
        MON: begin
          if (raw_block) begin
            if (THRESHOLD == 1) begin
              state_nxt   = DEAD;
              run_cnt_nxt = CNT_FULL;
              dead_entry  = 1'b1;
            end else begin
              state_nxt   = PEND;
              run_cnt_nxt = CNT_W'(1);
            end
          end else begin
            run_cnt_nxt = '0;
          end
        end
        PEND: begin
          if (!raw_block) begin
            state_nxt   = MON;
            run_cnt_nxt = '0;
          end else if (run_cnt == CNT_LAST) begin
            state_nxt   = DEAD;
            run_cnt_nxt = CNT_FULL;
            dead_entry  = 1'b1;
          end else begin
            run_cnt_nxt = run_cnt + CNT_W'(1);
          end
        end
        DEAD: begin
          if (!raw_block) begin
            state_nxt   = MON;
            run_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt   = MON;
          run_cnt_nxt = '0;
        end
      endcase
    end
  end

  // A DEAD entry coinciding with clear wins: the count restarts at one.
  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      deadlock_sticky <= 1'b0;
      block_snapshot  <= '0;
      deadlock_events <= '0;
    end else if (dead_entry) begin
      deadlock_sticky <= 1'b1;
      block_snapshot  <= axis_block_sigs;
      if (clear)
        deadlock_events <= EVT_W'(1);
      else if (deadlock_events != EVT_MAX)
        deadlock_events <= deadlock_events + EVT_W'(1);
    end else if (clear) begin
      deadlock_sticky <= 1'b0;
      block_snapshot  <= '0;
      deadlock_events <= '0;
    end
  end

  assign kernel_block  = (state == DEAD);
  assign starved_ports = ~block_snapshot & {N_AXIS{deadlock_sticky}};

endmodule

// File: tb/tb_yolo_deadlock_monitor_nport.sv
// Bench for yolo_deadlock_monitor_nport: one instance with THRESHOLD=2 and
// one with THRESHOLD=5, sharing the same stimulus.
module tb_yolo_deadlock_monitor_nport;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear;
  logic [1:0] axis;
  logic [1:0] idle;
  logic [1:0] blk;

  logic       kb_a, st_a, kb_b, st_b;
  logic [1:0] snap_a, starv_a, snap_b, starv_b;
  logic [7:0] ev_a, ev_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  yolo_deadlock_monitor_nport #(.N_AXIS(2), .N_INST(2), .THRESHOLD(2), .EVT_W(8)) dut_a (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst),
    .enable               (enable),
    .clear                (clear),
    .axis_block_sigs      (axis),
    .inst_idle_sigs       (idle),
    .inst_block_sigs      (blk),
    .kernel_block         (kb_a),
    .deadlock_sticky      (st_a),
    .block_snapshot       (snap_a),
    .starved_ports        (starv_a),
    .deadlock_events      (ev_a)
  );

  yolo_deadlock_monitor_nport #(.N_AXIS(2), .N_INST(2), .THRESHOLD(5), .EVT_W(8)) dut_b (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst),
    .enable               (enable),
    .clear                (clear),
    .axis_block_sigs      (axis),
    .inst_idle_sigs       (idle),
    .inst_block_sigs      (blk),
    .kernel_block         (kb_b),
    .deadlock_sticky      (st_b),
    .block_snapshot       (snap_b),
    .starved_ports        (starv_b),
    .deadlock_events      (ev_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] i, input logic [1:0] b, input logic [1:0] a);
    idle = i;
    blk  = b;
    axis = a;
  endtask

  task automatic raw_on(input logic [1:0] a);
    drive(2'b00, 2'b11, a);
  endtask

  task automatic raw_off();
    drive(2'b00, 2'b00, 2'b00);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic kb, input logic st,
                       input logic [1:0] snap, input logic [7:0] ev);
    chk({tag, "_kb"},    32'(kb_a),    32'(kb));
    chk({tag, "_st"},    32'(st_a),    32'(st));
    chk({tag, "_snap"},  32'(snap_a),  32'(snap));
    chk({tag, "_starv"}, 32'(starv_a), 32'(~snap & {2{st}}));
    chk({tag, "_ev"},    32'(ev_a),    32'(ev));
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    raw_off();
    tick();
    tick();
    chk_a("reset", 1'b0, 1'b0, 2'b00, 8'd0);
    chk("reset_b_kb", 32'(kb_b), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    tick();

    // 1) basic deadlock on port 0
    raw_on(2'b01);
    tick();
    chk_a("t1_pend", 1'b0, 1'b0, 2'b00, 8'd0);
    tick();
    chk_a("t1_dead", 1'b1, 1'b1, 2'b01, 8'd1);
    chk("t1_b_kb", 32'(kb_b), 32'd0);
    raw_off();
    tick();
    chk_a("t1_recover", 1'b0, 1'b1, 2'b01, 8'd1);

    // 2) single raw cycle never reaches DEAD
    pulse_clear();
    chk_a("t2_clear", 1'b0, 1'b0, 2'b00, 8'd0);
    raw_on(2'b01);
    tick();
    raw_off();
    tick();
    tick();
    chk_a("t2_nodead", 1'b0, 1'b0, 2'b00, 8'd0);

    // raw_block decode: all idle, no stalled port, mixed idle/blocked
    drive(2'b11, 2'b00, 2'b11);
    tick(); tick(); tick();
    chk("dec_allidle_kb", 32'(kb_a), 32'd0);
    drive(2'b01, 2'b10, 2'b00);
    tick(); tick(); tick();
    chk("dec_noaxis_kb", 32'(kb_a), 32'd0);
    drive(2'b01, 2'b00, 2'b11);
    tick(); tick(); tick();
    chk("dec_notblk_kb", 32'(kb_a), 32'd0);
    drive(2'b01, 2'b10, 2'b10);
    tick(); tick();
    chk_a("dec_mixed", 1'b1, 1'b1, 2'b10, 8'd1);
    raw_off();
    tick();

    // 3) THRESHOLD=5 instance: 4 on / 1 off never reaches DEAD
    for (int r = 0; r < 3; r++) begin
      raw_on(2'b11);
      for (int c = 0; c < 4; c++) tick();
      chk("t3_run_b_kb", 32'(kb_b), 32'd0);
      raw_off();
      tick();
    end
    chk("t3_b_st", 32'(st_b), 32'd0);
    raw_on(2'b11);
    for (int c = 0; c < 4; c++) tick();
    chk("t3_4th_b_kb", 32'(kb_b), 32'd0);
    tick();
    chk("t3_5th_b_kb", 32'(kb_b), 32'd1);
    chk("t3_b_ev", 32'(ev_b), 32'd1);
    chk("t3_b_starv", 32'(starv_b), 32'd0);
    raw_off();
    tick();
    chk("t3_b_fall", 32'(kb_b), 32'd0);

    // 4) deadlock, recovery, second deadlock on port 1
    pulse_clear();
    raw_on(2'b01);
    tick(); tick();
    chk_a("t4_first", 1'b1, 1'b1, 2'b01, 8'd1);
    raw_off();
    tick();
    chk_a("t4_gap", 1'b0, 1'b1, 2'b01, 8'd1);
    raw_on(2'b10);
    tick();
    chk_a("t4_pend2", 1'b0, 1'b1, 2'b01, 8'd1);
    tick();
    chk_a("t4_second", 1'b1, 1'b1, 2'b10, 8'd2);
    raw_off();
    tick();

    // 5) clear on entry cycle, then clear while DEAD
    raw_on(2'b01);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_a("t5_entry_clr", 1'b1, 1'b1, 2'b01, 8'd1);
    tick();
    pulse_clear();
    chk_a("t5_dead_clr", 1'b1, 1'b0, 2'b00, 8'd0);
    raw_off();
    tick();

    // 6) reset while DEAD and mid-PEND
    raw_on(2'b01);
    tick(); tick();
    chk_a("t6_dead", 1'b1, 1'b1, 2'b01, 8'd1);
    rst = 1'b1;
    #2;
    chk_a("t6_rst_dead", 1'b0, 1'b0, 2'b00, 8'd0);
    rst = 1'b0;
    tick();
    chk("t6_fresh1_kb", 32'(kb_a), 32'd0);
    tick();
    chk("t6_fresh2_kb", 32'(kb_a), 32'd1);
    raw_off();
    tick();
    raw_on(2'b01);
    tick();
    rst = 1'b1;
    #2;
    chk_a("t6_rst_pend", 1'b0, 1'b0, 2'b00, 8'd0);
    rst = 1'b0;
    tick();
    chk("t6_pend_fresh1_kb", 32'(kb_a), 32'd0);
    tick();
    chk("t6_pend_fresh2_kb", 32'(kb_a), 32'd1);
    raw_off();
    tick();

    // enable low suppresses detection and holds status
    enable = 1'b0;
    raw_on(2'b10);
    tick(); tick(); tick();
    chk_a("en_off", 1'b0, 1'b1, 2'b01, 8'd1);
    enable = 1'b1;
    tick();
    chk("en_restart1_kb", 32'(kb_a), 32'd0);
    tick();
    chk_a("en_restart2", 1'b1, 1'b1, 2'b10, 8'd2);
    raw_off();
    tick();

    // event counter saturation
    pulse_clear();
    for (int k = 0; k < 260; k++) begin
      raw_on(2'b01);
      tick(); tick();
      raw_off();
      tick();
    end
    chk_a("sat", 1'b0, 1'b1, 2'b01, 8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
